// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display path.
package stopwatch_pkg;

  // Width of one display-digit code (0-9 digits, plus dash/blank codes).
  localparam int unsigned DigitW = 4;

  typedef logic [DigitW-1:0] digit_t;

  localparam digit_t DIG_DASH  = digit_t'(10);
  localparam digit_t DIG_BLANK = digit_t'(15);

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // One frame's worth of latched display digits.
  typedef struct packed {
    digit_t minutes;
    digit_t sec_tens;
    digit_t sec_units;
  } snap_t;

  // Splits seconds into tens/units with a compare chain rather than a divider;
  // out-of-range fields are replaced by dash codes.
  function automatic snap_t bcd_snapshot(input logic [5:0] sec, input logic [3:0] mins);
    snap_t      s;
    logic [5:0] base;
    s.sec_tens = digit_t'(0);
    base       = 6'd0;
    if (sec >= 6'd50) begin
      s.sec_tens = digit_t'(5);
      base       = 6'd50;
    end else if (sec >= 6'd40) begin
      s.sec_tens = digit_t'(4);
      base       = 6'd40;
    end else if (sec >= 6'd30) begin
      s.sec_tens = digit_t'(3);
      base       = 6'd30;
    end else if (sec >= 6'd20) begin
      s.sec_tens = digit_t'(2);
      base       = 6'd20;
    end else if (sec >= 6'd10) begin
      s.sec_tens = digit_t'(1);
      base       = 6'd10;
    end
    s.sec_units = digit_t'(sec - base);
    if (sec > 6'd59) begin
      s.sec_tens  = DIG_DASH;
      s.sec_units = DIG_DASH;
    end
    s.minutes = (mins > 4'd9) ? DIG_DASH : digit_t'(mins);
    return s;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Digit code to active-low 7-segment pattern; 10 is a dash, other codes blank.
module seg7_encode
  import stopwatch_pkg::*;
(
  input  digit_t     code_i,
  output logic [6:0] seg_o
);

  // Pure lookup, blank for anything not a digit or dash.
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      digit_t'(0):  seg_o = 7'b1000000;
      digit_t'(1):  seg_o = 7'b1111001;
      digit_t'(2):  seg_o = 7'b0100100;
      digit_t'(3):  seg_o = 7'b0110000;
      digit_t'(4):  seg_o = 7'b0011001;
      digit_t'(5):  seg_o = 7'b0010010;
      digit_t'(6):  seg_o = 7'b0000010;
      digit_t'(7):  seg_o = 7'b1111000;
      digit_t'(8):  seg_o = 7'b0000000;
      digit_t'(9):  seg_o = 7'b0010000;
      DIG_DASH:     seg_o = SEG_DASH;
      default:      seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Time-multiplexed 4-digit " M.SS" driver for a common-anode 7-segment display.
// The time is latched once per scan frame so a frame never mixes two readings.
module stopwatch_display_mux
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] seconds,
  input  logic [3:0] minutes,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [RefW-1:0] RefMax = RefW'(REFRESH_DIV - 1);
  localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_TICKS - 1);

  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]      idx_q, idx_d;
  snap_t           snap_q, snap_d;
  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic            phase_q, phase_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       tick;
  logic       frame_end;
  digit_t     cur_digit;
  logic       cur_dp;
  logic [6:0] cur_seg;

  assign tick      = (ref_cnt_q == RefMax);
  assign frame_end = tick && (idx_q == 2'd3);

  // Slot timing, digit index and the once-per-frame time snapshot.
  always_comb begin
    ref_cnt_d = tick ? '0 : ref_cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    snap_d    = frame_end ? bcd_snapshot(seconds, minutes) : snap_q;
  end

  // Blink phase counts slot ticks; held cleared while blinking is off so it
  // always restarts in the visible half.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    if (!blink_en) begin
      blk_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (tick) begin
      if (blk_cnt_q == BlkMax) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
  end

  // Select the digit code and decimal point for the current slot.
  always_comb begin
    cur_digit = DIG_BLANK;
    cur_dp    = 1'b1;
    unique case (idx_q)
      2'd0: cur_digit = snap_q.sec_units;
      2'd1: cur_digit = snap_q.sec_tens;
      2'd2: begin
        cur_digit = snap_q.minutes;
        cur_dp    = 1'b0;
      end
      2'd3: cur_digit = DIG_BLANK;
    endcase
  end

  seg7_encode u_seg7_encode (
    .code_i (cur_digit),
    .seg_o  (cur_seg)
  );

  // Next output values; the dark blink half overrides everything.
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = cur_seg;
    dp_d  = cur_dp;
    if (blink_en && phase_q) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  // All state, including the registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q <= '0;
      idx_q     <= 2'd0;
      snap_q    <= '0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Bench for stopwatch_display_mux: directed steps plus random input changes,
// checked every cycle against a cycle-count based reference model.
module tb_stopwatch_display_mux;

  localparam int DIV   = 4;
  localparam int BT    = 2;
  localparam int FRAME = 4 * DIV;

  localparam logic [6:0] S_DASH  = 7'b0111111;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [5:0] seconds  = 6'd0;
  logic [3:0] minutes  = 4'd0;
  logic       blink_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, latched time, blink ticks.
  int n         = 0;
  int snap_sec  = 0;
  int snap_min  = 0;
  int ben_ticks = 0;
  int last_idx  = 0;
  bit last_off  = 1'b0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  stopwatch_display_mux #(
    .REFRESH_DIV (DIV),
    .BLINK_TICKS (BT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seconds  (seconds),
    .minutes  (minutes),
    .blink_en (blink_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic logic [6:0] exp_digit_seg(input int idx);
    if (idx == 3) return S_BLANK;
    if (idx == 2) return (snap_min > 9) ? S_DASH : seg_tab[snap_min];
    if (snap_sec > 59) return S_DASH;
    return (idx == 0) ? seg_tab[snap_sec % 10] : seg_tab[snap_sec / 10];
  endfunction

  // One clock: predict the outputs after this edge, advance the model, compare.
  task automatic step();
    int         idx;
    bit         off;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    n++;
    idx = ((n - 1) / DIV) % 4;
    off = blink_en && (((ben_ticks / BT) % 2) == 1);
    if (off) begin
      e_an  = 4'b1111;
      e_seg = S_BLANK;
      e_dp  = 1'b1;
    end else begin
      e_an      = 4'b1111;
      e_an[idx] = 1'b0;
      e_seg     = exp_digit_seg(idx);
      e_dp      = (idx == 2) ? 1'b0 : 1'b1;
    end
    if (n % FRAME == 0) begin
      snap_sec = int'(seconds);
      snap_min = int'(minutes);
    end
    if (!blink_en) ben_ticks = 0;
    else if (n % DIV == 0) ben_ticks++;
    last_idx = idx;
    last_off = off;
    @(negedge clk);
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    if (!off) check("an_onehot", 32'($countones(~an)), 32'd1);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Step until the display shows the given slot (visible), with a cycle budget.
  task automatic run_to(input int target);
    bit found = 1'b0;
    for (int i = 0; i < 8 * FRAME && !found; i++) begin
      step();
      if (last_idx == target && !last_off) found = 1'b1;
    end
    check("run_to_slot", 32'(found), 32'd1);
  endtask

  task automatic model_reset();
    n         = 0;
    snap_sec  = 0;
    snap_min  = 0;
    ben_ticks = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'd1);
    repeat (2) @(negedge clk);
    model_reset();
    seconds = 6'd37;
    minutes = 4'd5;
    rst_n   = 1'b1;

    // First cycle after reset: slot 0 showing digit 0 from the cleared snapshot.
    step();
    check("first_an", 32'(an), 32'hE);
    check("first_seg", 32'(seg), 32'(7'b1000000));

    // Steady 5.37 from the second frame on.
    run(2 * FRAME);
    run_to(0);
    check("s37_units", 32'(seg), 32'(7'b1111000));
    run_to(1);
    check("s37_tens", 32'(seg), 32'(7'b0110000));
    check("s37_an1", 32'(an), 32'hD);
    // Mid-frame change must wait for the frame boundary.
    seconds = 6'd42;
    run_to(2);
    check("s37_min", 32'(seg), 32'(7'b0010010));
    check("s37_dp", 32'(dp), 32'd0);
    run_to(0);
    check("s42_units", 32'(seg), 32'(7'b0100100));
    run_to(1);
    check("s42_tens", 32'(seg), 32'(7'b0011001));

    // Counter wrap and out-of-range values.
    seconds = 6'd59;
    minutes = 4'd9;
    run(FRAME);
    run_to(0);
    check("s59_units", 32'(seg), 32'(7'b0010000));
    seconds = 6'd0;
    minutes = 4'd0;
    run(FRAME);
    run_to(2);
    check("wrap_min", 32'(seg), 32'(7'b1000000));
    seconds = 6'd60;
    minutes = 4'd12;
    run(FRAME);
    run_to(0);
    check("s60_units", 32'(seg), 32'(S_DASH));
    run_to(1);
    check("s60_tens", 32'(seg), 32'(S_DASH));
    run_to(2);
    check("m12_dash", 32'(seg), 32'(S_DASH));
    check("m12_dp", 32'(dp), 32'd0);

    // Blinking while paused, then release.
    seconds = 6'd37;
    minutes = 4'd5;
    run(FRAME);
    blink_en = 1'b1;
    run(8 * DIV + 3);
    blink_en = 1'b0;
    run(2 * DIV);
    blink_en = 1'b1;
    run(6 * DIV);
    blink_en = 1'b0;

    // Random inputs and blink toggling.
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) seconds = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 11) == 0) minutes = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
    end
    blink_en = 1'b0;

    // Steady inputs: anode rotation with exactly one digit driven.
    seconds = 6'd12;
    minutes = 4'd3;
    run(16 * DIV);

    // Asynchronous reset in the middle of the minutes slot.
    run_to(2);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp", 32'(dp), 32'd1);
    @(negedge clk);
    check("held_an", 32'(an), 32'hF);
    model_reset();
    rst_n = 1'b1;
    step();
    check("rel_an", 32'(an), 32'hE);
    check("rel_seg", 32'(seg), 32'(7'b1000000));
    run(3 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
